// File: rtl/axi_master_arbiter_w.sv
// Two-master AXI write-channel arbiter: one owner of the shared AW/W/B path from AW handshake to B handshake.
// Optional AXI_WARB_ROUND_ROBIN_EN: round-robin tie-break; otherwise m0 has fixed priority.
`timescale 1ns/1ps

module axi_master_arbiter_w #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned USER_WIDTH = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  // master 0
  input  logic [ADDR_WIDTH-1:0] m0_AWADDR,
  input  logic [ID_WIDTH-1:0]   m0_AWID,
  input  logic                  m0_AWVALID,
  output logic                  m0_AWREADY,
  input  logic                  m0_WVALID,
  input  logic                  m0_WLAST,
  output logic                  m0_WREADY,
  output logic                  m0_BVALID,
  input  logic                  m0_BREADY,
  // master 1
  input  logic [ADDR_WIDTH-1:0] m1_AWADDR,
  input  logic [ID_WIDTH-1:0]   m1_AWID,
  input  logic                  m1_AWVALID,
  output logic                  m1_AWREADY,
  input  logic                  m1_WVALID,
  input  logic                  m1_WLAST,
  output logic                  m1_WREADY,
  output logic                  m1_BVALID,
  input  logic                  m1_BREADY,
  // B payload broadcast to both masters
  output logic [ID_WIDTH-1:0]   m_BID,
  output logic [1:0]            m_BRESP,
  output logic [USER_WIDTH-1:0] m_BUSER,
  // shared slave side
  output logic [ADDR_WIDTH-1:0] s_AWADDR,
  output logic [ID_WIDTH-1:0]   s_AWID,
  output logic                  s_AWVALID,
  input  logic                  s_AWREADY,
  output logic                  s_WVALID,
  output logic                  s_WLAST,
  input  logic                  s_WREADY,
  input  logic [ID_WIDTH-1:0]   s_BID,
  input  logic [1:0]            s_BRESP,
  input  logic [USER_WIDTH-1:0] s_BUSER,
  input  logic                  s_BVALID,
  output logic                  s_BREADY,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [1:0]            grant_nxt;
  logic [1:0]            pick;

  logic                  in_aw;
  logic                  in_w;
  logic                  in_b;

  logic [ADDR_WIDTH-1:0] sel_awaddr;
  logic [ID_WIDTH-1:0]   sel_awid;
  logic                  sel_awvalid;
  logic                  sel_wvalid;
  logic                  sel_wlast;
  logic                  sel_bready;

  logic                  aw_hs;
  logic                  w_last_hs;
  logic                  b_hs;

  assign in_aw = (state == ST_AW);
  assign in_w  = (state == ST_W);
  assign in_b  = (state == ST_B);

  // Granted master's request signals; all zero while nobody owns the path
  always_comb begin
    sel_awaddr  = '0;
    sel_awid    = '0;
    sel_awvalid = 1'b0;
    sel_wvalid  = 1'b0;
    sel_wlast   = 1'b0;
    sel_bready  = 1'b0;
    if (grant[0]) begin
      sel_awaddr  = m0_AWADDR;
      sel_awid    = m0_AWID;
      sel_awvalid = m0_AWVALID;
      sel_wvalid  = m0_WVALID;
      sel_wlast   = m0_WLAST;
      sel_bready  = m0_BREADY;
    end else if (grant[1]) begin
      sel_awaddr  = m1_AWADDR;
      sel_awid    = m1_AWID;
      sel_awvalid = m1_AWVALID;
      sel_wvalid  = m1_WVALID;
      sel_wlast   = m1_WLAST;
      sel_bready  = m1_BREADY;
    end
  end

  // Forward onto the shared bus only in the phase that owns each channel,
  // so early W beats from the granted master stall until AW completes
  assign s_AWVALID = in_aw & sel_awvalid;
  assign s_AWADDR  = in_aw ? sel_awaddr : '0;
  assign s_AWID    = in_aw ? sel_awid : '0;
  assign s_WVALID  = in_w & sel_wvalid;
  assign s_WLAST   = in_w & sel_wlast;
  assign s_BREADY  = in_b & sel_bready;

  assign m0_AWREADY = in_aw & grant[0] & s_AWREADY;
  assign m0_WREADY  = in_w  & grant[0] & s_WREADY;
  assign m0_BVALID  = in_b  & grant[0] & s_BVALID;
  assign m1_AWREADY = in_aw & grant[1] & s_AWREADY;
  assign m1_WREADY  = in_w  & grant[1] & s_WREADY;
  assign m1_BVALID  = in_b  & grant[1] & s_BVALID;

  assign m_BID   = s_BID;
  assign m_BRESP = s_BRESP;
  assign m_BUSER = s_BUSER;

  assign aw_hs     = s_AWVALID & s_AWREADY;
  assign w_last_hs = s_WVALID & s_WREADY & s_WLAST;
  assign b_hs      = s_BVALID & s_BREADY;

`ifdef AXI_WARB_ROUND_ROBIN_EN
  // prio=0 prefers m0, prio=1 prefers m1; points away from the master just served
  logic prio;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      prio <= 1'b0;
    end else if (b_hs) begin
      prio <= grant[0];
    end
  end

  always_comb begin
    pick = 2'b00;
    if (m0_AWVALID && m1_AWVALID) begin
      pick = prio ? 2'b10 : 2'b01;
    end else if (m0_AWVALID) begin
      pick = 2'b01;
    end else if (m1_AWVALID) begin
      pick = 2'b10;
    end
  end
`else
  // Fixed priority: m1 wins only when m0 is not requesting
  always_comb begin
    pick = 2'b00;
    if (m0_AWVALID) begin
      pick = 2'b01;
    end else if (m1_AWVALID) begin
      pick = 2'b10;
    end
  end
`endif

  // Next-state and next-grant
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      ST_IDLE: begin
        if (pick != 2'b00) begin
          state_nxt = ST_AW;
          grant_nxt = pick;
        end
      end
      ST_AW: begin
        if (aw_hs) begin
          state_nxt = ST_W;
        end
      end
      ST_W: begin
        if (w_last_hs) begin
          state_nxt = ST_B;
        end
      end
      ST_B: begin
        if (b_hs) begin
          state_nxt = ST_IDLE;
          grant_nxt = 2'b00;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= ST_IDLE;
      grant <= 2'b00;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

endmodule

// File: tb/tb_axi_master_arbiter_w.sv
// Self-checking bench for axi_master_arbiter_w: directed vector table, hand sequences, random vs reference model.
`timescale 1ns/1ps

module tb_axi_master_arbiter_w;

  localparam int unsigned AW = 64;
  localparam int unsigned IW = 8;
  localparam int unsigned UW = 8;
  localparam logic [AW-1:0] ADDR0 = 64'h0000_0000_8000_0000;
  localparam logic [AW-1:0] ADDR1 = 64'h0000_1234_0000_1000;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic [AW-1:0] m0_AWADDR, m1_AWADDR, s_AWADDR;
  logic [IW-1:0] m0_AWID, m1_AWID, s_AWID;
  logic m0_AWVALID, m0_AWREADY, m0_WVALID, m0_WLAST, m0_WREADY, m0_BVALID, m0_BREADY;
  logic m1_AWVALID, m1_AWREADY, m1_WVALID, m1_WLAST, m1_WREADY, m1_BVALID, m1_BREADY;
  logic [IW-1:0] m_BID, s_BID;
  logic [1:0]    m_BRESP, s_BRESP;
  logic [UW-1:0] m_BUSER, s_BUSER;
  logic s_AWVALID, s_AWREADY, s_WVALID, s_WLAST, s_WREADY, s_BVALID, s_BREADY;
  logic [1:0] grant;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  axi_master_arbiter_w #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .USER_WIDTH(UW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m0_AWADDR(m0_AWADDR), .m0_AWID(m0_AWID), .m0_AWVALID(m0_AWVALID), .m0_AWREADY(m0_AWREADY),
    .m0_WVALID(m0_WVALID), .m0_WLAST(m0_WLAST), .m0_WREADY(m0_WREADY),
    .m0_BVALID(m0_BVALID), .m0_BREADY(m0_BREADY),
    .m1_AWADDR(m1_AWADDR), .m1_AWID(m1_AWID), .m1_AWVALID(m1_AWVALID), .m1_AWREADY(m1_AWREADY),
    .m1_WVALID(m1_WVALID), .m1_WLAST(m1_WLAST), .m1_WREADY(m1_WREADY),
    .m1_BVALID(m1_BVALID), .m1_BREADY(m1_BREADY),
    .m_BID(m_BID), .m_BRESP(m_BRESP), .m_BUSER(m_BUSER),
    .s_AWADDR(s_AWADDR), .s_AWID(s_AWID), .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY),
    .s_WVALID(s_WVALID), .s_WLAST(s_WLAST), .s_WREADY(s_WREADY),
    .s_BID(s_BID), .s_BRESP(s_BRESP), .s_BUSER(s_BUSER), .s_BVALID(s_BVALID), .s_BREADY(s_BREADY),
    .grant(grant)
  );

  // in : {m0_awv, m1_awv, m0_wv, m0_wl, m1_wv, m1_wl, m0_br, m1_br, s_awr, s_wr, s_bv}
  // exp: {grant[1:0], s_awv, s_wv, s_wl, s_br, m0_awr, m0_wr, m0_bv, m1_awr, m1_wr, m1_bv}
  typedef struct packed {
    logic [10:0] in;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl [17];

  function automatic logic [11:0] act_bits();
    return {grant, s_AWVALID, s_WVALID, s_WLAST, s_BREADY,
            m0_AWREADY, m0_WREADY, m0_BVALID, m1_AWREADY, m1_WREADY, m1_BVALID};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_in();
    {m0_AWVALID, m1_AWVALID, m0_WVALID, m0_WLAST, m1_WVALID, m1_WLAST,
     m0_BREADY, m1_BREADY, s_AWREADY, s_WREADY, s_BVALID} = '0;
    m0_AWADDR = ADDR0;  m0_AWID = 8'h11;
    m1_AWADDR = ADDR1;  m1_AWID = 8'h22;
    s_BID = 8'h05;  s_BRESP = 2'b00;  s_BUSER = 8'hA5;
  endtask

  task automatic do_reset();
    clr_in();
    @(negedge ACLK);
    ARESETn = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  // Reference model: who owns the path and which channel phase it is in
  int owner;   // -1 none, else master index
  int phase;   // 0 idle, 1 address, 2 data, 3 response
  int pref;    // master favoured on a tie

  logic [1:0] exp3 [4];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Directed table: m0 4-beat burst with toggling WREADY, then m1 single beat
    tbl[0]  = {11'b10000000100, 12'b00_0000_000_000};
    tbl[1]  = {11'b10000000100, 12'b01_1000_100_000};
    tbl[2]  = {11'b00100000010, 12'b01_0100_010_000};
    tbl[3]  = {11'b00100000000, 12'b01_0100_000_000};
    tbl[4]  = {11'b00100000010, 12'b01_0100_010_000};
    tbl[5]  = {11'b00100000000, 12'b01_0100_000_000};
    tbl[6]  = {11'b00100000010, 12'b01_0100_010_000};
    tbl[7]  = {11'b00110000000, 12'b01_0110_000_000};
    tbl[8]  = {11'b00110000010, 12'b01_0110_010_000};
    tbl[9]  = {11'b01000010001, 12'b01_0001_001_000};
    tbl[10] = {11'b01000000000, 12'b00_0000_000_000};
    tbl[11] = {11'b01000000000, 12'b10_1000_000_000};
    tbl[12] = {11'b01000000100, 12'b10_1000_000_100};
    tbl[13] = {11'b10101100010, 12'b10_0110_000_010};
    tbl[14] = {11'b10000000001, 12'b10_0000_000_001};
    tbl[15] = {11'b10000001001, 12'b10_0001_000_001};
    tbl[16] = {11'b00000000000, 12'b00_0000_000_000};

`ifdef AXI_WARB_ROUND_ROBIN_EN
    exp3[0] = 2'b01; exp3[1] = 2'b10; exp3[2] = 2'b01; exp3[3] = 2'b10;
`else
    exp3[0] = 2'b01; exp3[1] = 2'b01; exp3[2] = 2'b01; exp3[3] = 2'b01;
`endif

    clr_in();
    #1;
    chk("reset_outs", act_bits(), 12'h000);
    chk("reset_awaddr", s_AWADDR, '0);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(negedge ACLK);
      {m0_AWVALID, m1_AWVALID, m0_WVALID, m0_WLAST, m1_WVALID, m1_WLAST,
       m0_BREADY, m1_BREADY, s_AWREADY, s_WREADY, s_BVALID} = tbl[i].in;
      #1;
      chk($sformatf("tbl%0d", i), act_bits(), tbl[i].exp);
      if (tbl[i].exp[11:10] == 2'b00)
        chk($sformatf("tbl%0d_addr_idle", i), s_AWADDR, '0);
      else if (tbl[i].exp[9])
        chk($sformatf("tbl%0d_addr", i), s_AWADDR, tbl[i].exp[10] ? ADDR0 : ADDR1);
      if (i == 9)
        chk("tbl9_bpayload", {m_BID, m_BRESP}, {8'h05, 2'b00});
    end

    // Early W from m1 is stalled until its AW completes
    do_reset();
    @(negedge ACLK); m1_WVALID = 1; m1_WLAST = 1; s_WREADY = 1; #1;
    chk("earlyw_c0", {grant, s_WVALID, m1_WREADY}, 4'b0000);
    @(negedge ACLK); #1;
    chk("earlyw_c1", {grant, s_WVALID, m1_WREADY}, 4'b0000);
    @(negedge ACLK); m1_AWVALID = 1; s_AWREADY = 0; #1;
    chk("earlyw_c2", {grant, s_WVALID, m1_WREADY}, 4'b0000);
    @(negedge ACLK); s_AWREADY = 1; #1;
    chk("earlyw_aw", {grant, s_AWVALID, s_WVALID, m1_WREADY}, 5'b10100);
    @(negedge ACLK); m1_AWVALID = 0; s_AWREADY = 0; #1;
    chk("earlyw_beat", {s_WVALID, s_WLAST, m1_WREADY}, 3'b111);
    @(negedge ACLK); s_WREADY = 0; s_BVALID = 1; m1_BREADY = 1; #1;
    chk("earlyw_b", {m1_BVALID, s_BREADY, m0_BVALID}, 3'b110);

    // Async reset while m1 is in its data phase
    do_reset();
    @(negedge ACLK); m1_AWVALID = 1; s_AWREADY = 1;
    @(negedge ACLK);
    @(negedge ACLK); m1_AWVALID = 0; m1_WVALID = 1; s_WREADY = 0;
    m1_BREADY = 1; s_BVALID = 1; #1;
    chk("rst_pre_w", {grant, s_WVALID}, 3'b101);
    #2 ARESETn = 0; #1;
    chk("rst_async", {grant, s_WVALID, s_BREADY, m1_WREADY, m1_BVALID}, 6'b0);
    @(negedge ACLK); clr_in(); ARESETn = 1;
    @(negedge ACLK); m0_AWVALID = 1; m1_AWVALID = 1; #1;
    chk("rst_after_idle", grant, 2'b00);
    @(negedge ACLK); #1;
    chk("rst_after_m0pri", grant, 2'b01);

    // B stalled by m0_BREADY=0 while m1 waits
    do_reset();
    @(negedge ACLK); m0_AWVALID = 1; m1_AWVALID = 1; s_AWREADY = 1;
    @(negedge ACLK); #1;
    chk("bstall_grant", grant, 2'b01);
    @(negedge ACLK); m0_AWVALID = 0; m0_WVALID = 1; m0_WLAST = 1; s_WREADY = 1;
    @(negedge ACLK); m0_WVALID = 0; s_BVALID = 1; m0_BREADY = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bstall_c%0d", k), {grant, m0_BVALID, s_BREADY, m1_AWREADY, m1_BVALID}, 6'b01_1000);
      @(negedge ACLK);
    end
    m0_BREADY = 1; #1;
    chk("bstall_hs", {grant, s_BREADY, m0_BVALID}, 4'b0111);
    @(negedge ACLK); m0_BREADY = 0; s_BVALID = 0; #1;
    chk("bstall_idle", grant, 2'b00);
    @(negedge ACLK); #1;
    chk("bstall_m1", {grant, s_AWVALID}, 3'b101);
    chk("bstall_m1addr", s_AWADDR, ADDR1);

    // Both masters requesting back to back, single-beat transactions
    do_reset();
    @(negedge ACLK);
    m0_AWVALID = 1; m1_AWVALID = 1; m0_WVALID = 1; m1_WVALID = 1; m0_WLAST = 1; m1_WLAST = 1;
    m0_BREADY = 1; m1_BREADY = 1; s_AWREADY = 1; s_WREADY = 1; s_BVALID = 1;
    for (int t = 0; t < 4; t++) begin
      #1;
      chk($sformatf("alt%0d_idle", t), grant, 2'b00);
      @(negedge ACLK); #1;
      chk($sformatf("alt%0d_grant", t), grant, exp3[t]);
      @(negedge ACLK);
      @(negedge ACLK);
      @(negedge ACLK);
    end

    // Random traffic against the reference model
    do_reset();
    owner = -1; phase = 0; pref = 0;
    for (int c = 0; c < 1500; c++) begin
      logic awv [2];
      logic wv [2];
      logic wl [2];
      logic br [2];
      logic [AW-1:0] ad [2];
      logic [IW-1:0] id [2];
      logic [11:0] e;
      logic e_awv, e_wv, e_wl, e_br;
      logic [1:0] e_grant;
      @(negedge ACLK);
      m0_AWVALID = 1'($urandom_range(0, 1));
      m1_AWVALID = 1'($urandom_range(0, 1));
      m0_WVALID  = 1'($urandom_range(0, 1));
      m1_WVALID  = 1'($urandom_range(0, 1));
      m0_WLAST   = ($urandom_range(0, 2) == 0);
      m1_WLAST   = ($urandom_range(0, 2) == 0);
      m0_BREADY  = 1'($urandom_range(0, 1));
      m1_BREADY  = 1'($urandom_range(0, 1));
      s_AWREADY  = 1'($urandom_range(0, 1));
      s_WREADY   = 1'($urandom_range(0, 1));
      s_BVALID   = 1'($urandom_range(0, 1));
      m0_AWADDR  = {$urandom, $urandom};
      m1_AWADDR  = {$urandom, $urandom};
      m0_AWID    = 8'($urandom);
      m1_AWID    = 8'($urandom);
      s_BID      = 8'($urandom);
      s_BRESP    = 2'($urandom);
      s_BUSER    = 8'($urandom);
      awv[0] = m0_AWVALID; awv[1] = m1_AWVALID;
      wv[0]  = m0_WVALID;  wv[1]  = m1_WVALID;
      wl[0]  = m0_WLAST;   wl[1]  = m1_WLAST;
      br[0]  = m0_BREADY;  br[1]  = m1_BREADY;
      ad[0]  = m0_AWADDR;  ad[1]  = m1_AWADDR;
      id[0]  = m0_AWID;    id[1]  = m1_AWID;
      #1;
      e_grant = (owner < 0) ? 2'b00 : 2'(1 << owner);
      e_awv = (owner >= 0) && phase == 1 && awv[owner];
      e_wv  = (owner >= 0) && phase == 2 && wv[owner];
      e_wl  = (owner >= 0) && phase == 2 && wl[owner];
      e_br  = (owner >= 0) && phase == 3 && br[owner];
      e = {e_grant, e_awv, e_wv, e_wl, e_br,
           owner == 0 && phase == 1 && s_AWREADY,
           owner == 0 && phase == 2 && s_WREADY,
           owner == 0 && phase == 3 && s_BVALID,
           owner == 1 && phase == 1 && s_AWREADY,
           owner == 1 && phase == 2 && s_WREADY,
           owner == 1 && phase == 3 && s_BVALID};
      chk($sformatf("rand%0d", c), act_bits(), e);
      if (owner < 0)
        chk($sformatf("rand%0d_addr_idle", c), {s_AWADDR, s_AWID}, '0);
      else if (phase == 1)
        chk($sformatf("rand%0d_addr", c), {s_AWADDR, s_AWID}, {ad[owner], id[owner]});
      chk($sformatf("rand%0d_bpay", c), {m_BID, m_BRESP, m_BUSER}, {s_BID, s_BRESP, s_BUSER});
      // advance the model with the inputs the DUT samples at the next rising edge
      case (phase)
        0: if (awv[0] || awv[1]) begin
             owner = (awv[0] && awv[1]) ? pref : (awv[0] ? 0 : 1);
             phase = 1;
           end
        1: if (awv[owner] && s_AWREADY) phase = 2;
        2: if (wv[owner] && s_WREADY && wl[owner]) phase = 3;
        default: if (s_BVALID && br[owner]) begin
`ifdef AXI_WARB_ROUND_ROBIN_EN
             pref = 1 - owner;
`endif
             owner = -1;
             phase = 0;
           end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_master_arbiter_w.md
Name: axi_master_arbiter_w

Overview:
Two-master write-channel arbiter for the AXI interconnect; sits directly upstream of the write-path slave mux.
- Grants one master ownership of the shared AW/W/B path.
- Forwards that master's AWADDR/AWID/AWVALID, WVALID/WLAST and BREADY onto the shared s_* bus.
- Returns the shared AWREADY/WREADY/BVALID/B payload to the granted master only.
- Grant is held from AW handshake through the B handshake: one outstanding write transaction at a time.

Parameters:
ADDR_WIDTH, 64, write address width
ID_WIDTH, 8, AWID/BID width
USER_WIDTH, 8, BUSER width

Ports:
ACLK  input  1  clock, all state on rising edge
ARESETn  input  1  asynchronous active-low reset
m0_AWADDR  input  ADDR_WIDTH  master 0 write address
m0_AWID  input  ID_WIDTH  master 0 write ID
m0_AWVALID  input  1  master 0 AW valid
m0_AWREADY  output  1  master 0 AW ready
m0_WVALID  input  1  master 0 W valid
m0_WLAST  input  1  master 0 last beat
m0_WREADY  output  1  master 0 W ready
m0_BVALID  output  1  master 0 B valid
m0_BREADY  input  1  master 0 B ready
m1_* (AWADDR, AWID, AWVALID, AWREADY, WVALID, WLAST, WREADY, BVALID, BREADY)  same directions/widths as m0_*  master 1
m_BID  output  ID_WIDTH  B ID, broadcast to both masters
m_BRESP  output  2  B response, broadcast
m_BUSER  output  USER_WIDTH  B user, broadcast
s_AWADDR  output  ADDR_WIDTH  shared AW address to slave mux
s_AWID  output  ID_WIDTH  shared AW ID
s_AWVALID  output  1  shared AW valid
s_AWREADY  input  1  shared AW ready
s_WVALID  output  1  shared W valid
s_WLAST  output  1  shared W last
s_WREADY  input  1  shared W ready
s_BID  input  ID_WIDTH  shared B ID
s_BRESP  input  2  shared B response
s_BUSER  input  USER_WIDTH  shared B user
s_BVALID  input  1  shared B valid
s_BREADY  output  1  shared B ready
grant  output  2  one-hot registered grant {m1,m0}; drives external WDATA/WSTRB mux

Behaviour:
- Reset values: state IDLE, grant=2'b00, priority pointer=0 (m0 preferred).
- Outputs while no master is granted: all s_* valids/ready = 0; all m*_READY/BVALID = 0; s_AWADDR/s_AWID = 0.
- Asynchronous reset mid-transaction: immediately returns to IDLE with outputs cleared; the in-flight transaction is abandoned.
- FSM states: IDLE, AW, W, B.
- IDLE:
  - If any mX_AWVALID is sampled high, register the grant and go to AW.
  - Both requesting: grant the master selected by the priority pointer.
  - Latency: AWVALID high in cycle n -> grant and s_AWVALID high in cycle n+1.
- AW: s_AWVALID/ADDR/ID = granted master's; granted mX_AWREADY = s_AWREADY. On s_AWVALID & s_AWREADY -> W.
- W:
  - s_WVALID/WLAST = granted master's; granted mX_WREADY = s_WREADY.
  - Beat handshake with WLAST=1 -> B; handshakes without WLAST stay in W.
  - W presented by a master before its AW is granted is stalled (WREADY=0), not dropped.
- B:
  - Granted mX_BVALID = s_BVALID; s_BREADY = granted mX_BREADY.
  - On handshake -> IDLE, grant cleared, priority pointer set to the master not just served.
- Non-granted master always sees AWREADY=WREADY=BVALID=0. Its AWVALID may stay high indefinitely; it is served on the next IDLE arbitration.
- Simultaneous B handshake and new AWVALID: the new request is arbitrated only after one IDLE cycle. Minimum gap between transactions is 1 cycle.
- Ready/valid forwarding within AW/W/B is combinational from the registered grant and state; no data buffering.

Optional Feature:
AXI_WARB_ROUND_ROBIN_EN
- Defined: priority pointer toggles after each completed B handshake (round-robin, as above).
- Undefined: pointer logic removed; m0 always wins simultaneous requests (fixed priority); m1 is granted only when m0_AWVALID is low in IDLE.

Test Plan:
1. Reset, m0 AWVALID=1 AWADDR=0x8000_0000 with s_AWREADY=1 -> grant=01 next cycle, s_AWADDR=0x8000_0000, m0_AWREADY=1 same cycle; m1_AWREADY=0.
2. m0 4-beat burst (WLAST on beat 4), s_WREADY toggling 1/0 -> exactly 4 handshakes on s_W; state enters B only after beat 4; BRESP=2'b00 and BID=0x05 reach m0 with m0_BVALID=1, m1_BVALID=0.
3. m0 and m1 request continuously, each single-beat -> with _EN defined grants alternate 01,10,01,10; undefined -> always 01 while m0 requests.
4. m1 drives WVALID=1 two cycles before its AWVALID -> s_WVALID stays 0 and m1_WREADY=0 until the AW handshake completes; no beat is lost.
5. Assert ARESETn=0 during W state of m1 -> grant=00, s_WVALID=0, s_BREADY=0 asynchronously; after release, first new request is arbitrated from IDLE with m0 priority.
6. s_BVALID held with m0_BREADY=0 for 5 cycles -> stays in B, no new grant to pending m1; m0_BREADY=1 -> IDLE next cycle, m1 granted the cycle after.
